mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the data-side ports of the 256x8 RAM between two requesters:
  - port 0: core load/store unit;
  - port 1: loader/debug master.
- Per cycle, grants at most one read or write to the RAM's data read port A and write port. The instruction-fetch port (pc / data_out_B) bypasses this block.
- Tracks the single outstanding read and routes the RAM's 1-cycle-latency read data back to the requester that issued it.
- Supports a lock so one requester can hold the RAM across a multi-cycle sequence, e.g. read-modify-write.

Parameters:
- AW, 8, address width; must match the RAM depth of 2^AW.
- DW, 8, data width.

Ports:
- clk  in  1  system clock, rising edge.
- async_rst_n  in  1  asynchronous active-low reset. One clock; reset is asynchronous, active-low.
- req_valid[1:0]  in  2  request valid, one bit per requester.
- req_we[1:0]  in  2  1 = write, 0 = read.
- req_lock[1:0]  in  2  hold the grant after this transfer.
- req_addr0, req_addr1  in  AW each  request address.
- req_wdata0, req_wdata1  in  DW each  write data.
- req_ready[1:0]  out  2  request accepted this cycle.
- rsp_valid[1:0]  out  2  read data valid.
- rsp_rdata  out  DW  read data, shared by both requesters; qualified by rsp_valid.
- mem_read_en  out  1  to RAM read_en_A.
- mem_addr_read  out  AW  to RAM addr_read_A.
- mem_write_en  out  1  to RAM write_en.
- mem_addr_write  out  AW  to RAM addr_write.
- mem_wdata  out  DW  to RAM data.
- mem_rdata  in  DW  from RAM data_out_A.
- grant_owner  out  2  one-hot current lock owner, 0 when unlocked (status).

Behaviour:
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - req_ready is combinational from req_valid and state. At most one bit is set per cycle.
  - Requesters hold addr, we, wdata and lock stable while valid && !ready.
- Memory drive, cycle of acceptance:
  - Read: mem_read_en=1, mem_addr_read=req_addr.
  - Write: mem_write_en=1, mem_addr_write=req_addr, mem_wdata=req_wdata.
  - All mem_* enables are 0 in cycles with no transfer. Address and data lines are don't-care but driven from the port-0 mux.
- Read latency:
  - Read accepted in cycle T gives rsp_valid[i]=1 in T+1, with rsp_rdata=mem_rdata passed straight through.
  - A registered tag rd_pend/rd_owner selects which rsp_valid bit is set.
  - There is no response backpressure; the requester must take the data.
- Throughput: back-to-back reads are allowed, one per cycle; the T+1 response overlaps a new T+1 request.
- Write-then-read to the same address in consecutive cycles returns the new data.
- States:
  - UNLOCKED:
    - Arbitrate among valid requesters; fixed priority port 0 > port 1.
    - On transfer with req_lock[i]=1, go to LOCKED_i.
  - LOCKED_i:
    - Only port i can be granted. The other port's req_ready is 0 even if port i is idle.
    - On a port-i transfer with req_lock[i]=0, return to UNLOCKED after that transfer.
    - Deasserting valid alone does not release the lock.
- Reset (async assert, sync release):
  - State goes to UNLOCKED; rd_pend=0.
  - req_ready=0 while reset is asserted.
  - All outputs are 0, including rsp_rdata (forced to 0 while !rd_pend).
  - A read in flight when reset asserts is dropped: no rsp_valid after release.
- Simultaneous requests: the winner is taken per the priority rule; the loser stalls with req_ready=0 and keeps its request.

Optional Feature:
- MEM_ARB_RR_EN
- Defined: the UNLOCKED state uses round-robin.
  - A 1-bit last_grant register updates on every transfer.
  - On a tie, the port not granted last wins.
  - last_grant resets to 1, so port 0 wins the first tie.
- Undefined: fixed priority port 0 > port 1; no last_grant register.
- Locking behaviour is identical in both builds.

Test Plan:
- Single read: RAM[0x10]=0xA5; port 0 reads 0x10 at T -> ready0=1 at T; rsp_valid=2'b01 and rsp_rdata=0xA5 at T+1.
- Write then read: port 1 writes 0x3C to 0x20 at T, reads 0x20 at T+1 -> mem_write_en=1 at T; rsp_valid=2'b10 and rsp_rdata=0x3C at T+2.
- Contention: both request every cycle for 4 cycles.
  - Default build: port 0 granted all 4 cycles; ready1=0 throughout.
  - MEM_ARB_RR_EN build: grants go 0,1,0,1.
- Lock: port 1 reads 0x40 with lock=1, idles 2 cycles, writes 0x40 with lock=0 -> port 0, valid throughout, sees ready0=0 for 4 cycles; ready0=1 the cycle after the unlocking write; grant_owner=2'b10 during the lock.
- Reset mid-read: read accepted at T, async_rst_n=0 mid-T+0.5 -> rsp_valid stays 0; all outputs 0 during reset; state UNLOCKED after release.
- Back-to-back reads 0x00..0x03 from port 0 -> 4 consecutive rsp_valid pulses carrying RAM contents in order, no gaps.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the data side (read port A + write port) of the 256x8 RAM.
// Build option MEM_ARB_RR_EN: round-robin among unlocked requesters instead of fixed port-0 priority.
module mem_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          async_rst_n,
    input  logic [1:0]    req_valid,
    input  logic [1:0]    req_we,
    input  logic [1:0]    req_lock,
    input  logic [AW-1:0] req_addr0,
    input  logic [AW-1:0] req_addr1,
    input  logic [DW-1:0] req_wdata0,
    input  logic [DW-1:0] req_wdata1,
    output logic [1:0]    req_ready,
    output logic [1:0]    rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          mem_read_en,
    output logic [AW-1:0] mem_addr_read,
    output logic          mem_write_en,
    output logic [AW-1:0] mem_addr_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    grant_owner
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_LOCKED0  = 2'd1;
    localparam logic [1:0] ST_LOCKED1  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_owner_q, rd_owner_d;

    logic [1:0]    grant;
    logic          xfer;
    logic          sel;
    logic          sel_we;
    logic          sel_lock;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

`ifdef MEM_ARB_RR_EN
    logic          last_grant_q, last_grant_d;
`endif

    // Grant is purely combinational so a requester sees ready in the cycle it asks.
    always_comb begin
        grant = 2'b00;
        if (async_rst_n) begin
            case (state_q)
                ST_LOCKED0: grant[0] = req_valid[0];
                ST_LOCKED1: grant[1] = req_valid[1];
                default: begin
`ifdef MEM_ARB_RR_EN
                    if (&req_valid) begin
                        grant = last_grant_q ? 2'b01 : 2'b10;
                    end else begin
                        grant = req_valid;
                    end
`else
                    grant[0] = req_valid[0];
                    grant[1] = req_valid[1] & ~req_valid[0];
`endif
                end
            endcase
        end
    end

    // Port 0 is the default mux leg so idle cycles still present its address/data.
    always_comb begin
        xfer      = |grant;
        sel       = grant[1];
        sel_we    = sel ? req_we[1]   : req_we[0];
        sel_lock  = sel ? req_lock[1] : req_lock[0];
        sel_addr  = sel ? req_addr1   : req_addr0;
        sel_wdata = sel ? req_wdata1  : req_wdata0;
    end

    always_comb begin
        req_ready      = grant;
        mem_read_en    = xfer & ~sel_we;
        mem_write_en   = xfer &  sel_we;
        mem_addr_read  = async_rst_n ? sel_addr  : '0;
        mem_addr_write = async_rst_n ? sel_addr  : '0;
        mem_wdata      = async_rst_n ? sel_wdata : '0;
    end

    always_comb begin
        state_d    = state_q;
        rd_pend_d  = xfer & ~sel_we;
        rd_owner_d = sel;
        if (xfer) begin
            if (sel_lock) begin
                state_d = sel ? ST_LOCKED1 : ST_LOCKED0;
            end else begin
                state_d = ST_UNLOCKED;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (xfer) begin
            last_grant_d = sel;
        end
    end

    // Reset value 1 lets port 0 win the first tie.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q    <= ST_UNLOCKED;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // RAM read data is passed straight through; the tag only steers the valid bit.
    always_comb begin
        rsp_valid   = {rd_pend_q & rd_owner_q, rd_pend_q & ~rd_owner_q};
        rsp_rdata   = rd_pend_q ? mem_rdata : '0;
        grant_owner = {state_q == ST_LOCKED1, state_q == ST_LOCKED0};
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expectations, a negedge monitor checks them.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       async_rst_n;
    logic [1:0] req_valid, req_we, req_lock;
    logic [7:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic [1:0] req_ready, rsp_valid, grant_owner;
    logic [7:0] rsp_rdata;
    logic       mem_read_en, mem_write_en;
    logic [7:0] mem_addr_read, mem_addr_write, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .async_rst_n(async_rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_read_en(mem_read_en), .mem_addr_read(mem_addr_read),
        .mem_write_en(mem_write_en), .mem_addr_write(mem_addr_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .grant_owner(grant_owner)
    );

    // RAM model: contents reload while reset is held.
    logic [7:0] ram [256];

    function automatic logic [7:0] init_val(input int a);
        case (a)
            8'h00:   return 8'h11;
            8'h01:   return 8'h22;
            8'h02:   return 8'h33;
            8'h03:   return 8'h44;
            8'h10:   return 8'hA5;
            8'h11:   return 8'hB6;
            8'h40:   return 8'h5A;
            default: return 8'(a) ^ 8'hFF;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!async_rst_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        end else begin
            if (mem_write_en) ram[mem_addr_write] <= mem_wdata;
            if (mem_read_en)  mem_rdata <= ram[mem_addr_read];
        end
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        int         cyc;
        logic [1:0] ready;
        logic [1:0] owner;
        logic       re;
        logic       we;
        logic [7:0] addr;
    } ctl_t;

    typedef struct {
        int         cyc;
        logic [1:0] valid;
        logic [7:0] data;
    } rsp_t;

    ctl_t q_ctl[$];
    rsp_t q_rsp[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; e_ready/e_owner/e_rdata are the hand-computed expectations.
    task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] e_ready, input logic [1:0] e_owner,
                        input logic [7:0] e_rdata, input bit exp_rsp);
        ctl_t c;
        rsp_t r;
        @(posedge clk);
        #1;
        req_valid = v;  req_we = we;  req_lock = lk;
        req_addr0 = a0; req_addr1 = a1;
        req_wdata0 = d0; req_wdata1 = d1;
        c.cyc   = cyc;
        c.ready = e_ready;
        c.owner = e_owner;
        c.re    = 1'b0;
        c.we    = 1'b0;
        c.addr  = e_ready[1] ? a1 : a0;
        if (e_ready != 2'b00) begin
            c.we = e_ready[1] ? we[1] : we[0];
            c.re = ~c.we;
        end
        q_ctl.push_back(c);
        if (exp_rsp) begin
            r.cyc   = cyc + 1;
            r.valid = e_ready;
            r.data  = e_rdata;
            q_rsp.push_back(r);
        end
    endtask

    task automatic idle();
        step(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0);
    endtask

    // Monitor
    initial forever begin
        ctl_t c;
        rsp_t r;
        @(negedge clk);
        if (!async_rst_n) begin
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
            chk("rst_mem_en", 32'({mem_read_en, mem_write_en}), 0);
            chk("rst_mem_lines", 32'({mem_addr_read, mem_addr_write, mem_wdata}), 0);
            chk("rst_owner", 32'(grant_owner), 0);
        end else begin
            if (q_ctl.size() > 0 && q_ctl[0].cyc == cyc) begin
                c = q_ctl.pop_front();
                chk("req_ready", 32'(req_ready), 32'(c.ready));
                chk("grant_owner", 32'(grant_owner), 32'(c.owner));
                chk("mem_read_en", 32'(mem_read_en), 32'(c.re));
                chk("mem_write_en", 32'(mem_write_en), 32'(c.we));
                if (c.re) chk("mem_addr_read", 32'(mem_addr_read), 32'(c.addr));
                if (c.we) chk("mem_addr_write", 32'(mem_addr_write), 32'(c.addr));
                if (c.ready != 2'b00)
                    $display("cycle %0d: grant %b re=%0b we=%0b addr=%02h owner=%b",
                             cyc, req_ready, mem_read_en, mem_write_en, c.addr, grant_owner);
            end
            if (rsp_valid != 2'b00) begin
                if (q_rsp.size() == 0) begin
                    chk("unexpected_rsp_valid", 32'(rsp_valid), 0);
                end else begin
                    r = q_rsp.pop_front();
                    chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
                    chk("rsp_valid", 32'(rsp_valid), 32'(r.valid));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(r.data));
                    $display("cycle %0d: response valid=%b data=%02h", cyc, rsp_valid, rsp_rdata);
                end
            end else if (q_rsp.size() > 0 && q_rsp[0].cyc <= cyc) begin
                r = q_rsp.pop_front();
                chk("missing_rsp_valid", 32'(rsp_valid), 32'(r.valid));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [7:0] b2b_data [4];

    initial begin
        b2b_data[0] = 8'h11; b2b_data[1] = 8'h22; b2b_data[2] = 8'h33; b2b_data[3] = 8'h44;
        async_rst_n = 1'b0;
        req_valid = 2'b11; req_we = 2'b00; req_lock = 2'b00;
        req_addr0 = 8'h10; req_addr1 = 8'h11; req_wdata0 = 8'h00; req_wdata1 = 8'h00;
        repeat (3) @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk);
        #2 async_rst_n = 1'b1;

        // Contention, both reading every cycle
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            if (k % 2 == 0)
                step(2'b11, 2'b00, 2'b00, 8'h10, 8'h11, 8'h00, 8'h00, 2'b01, 2'b00, 8'hA5, 1'b1);
            else
                step(2'b11, 2'b00, 2'b00, 8'h10, 8'h11, 8'h00, 8'h00, 2'b10, 2'b00, 8'hB6, 1'b1);
`else
            step(2'b11, 2'b00, 2'b00, 8'h10, 8'h11, 8'h00, 8'h00, 2'b01, 2'b00, 8'hA5, 1'b1);
`endif
        end
        idle();

        // Single read port 0
        step(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 8'hA5, 1'b1);
        idle();

        // Port 1 write then read same address
        step(2'b10, 2'b10, 2'b00, 8'h00, 8'h20, 8'h00, 8'h3C, 2'b10, 2'b00, 8'h00, 1'b0);
        step(2'b10, 2'b00, 2'b00, 8'h00, 8'h20, 8'h00, 8'h00, 2'b10, 2'b00, 8'h3C, 1'b1);
        idle();

        // Lock held by port 1 across idle cycles, port 0 waits
        step(2'b10, 2'b00, 2'b10, 8'h40, 8'h40, 8'h00, 8'h00, 2'b10, 2'b00, 8'h5A, 1'b1);
        step(2'b01, 2'b00, 2'b00, 8'h40, 8'h40, 8'h00, 8'h00, 2'b00, 2'b10, 8'h00, 1'b0);
        step(2'b01, 2'b00, 2'b00, 8'h40, 8'h40, 8'h00, 8'h00, 2'b00, 2'b10, 8'h00, 1'b0);
        step(2'b11, 2'b10, 2'b00, 8'h40, 8'h40, 8'h00, 8'h77, 2'b10, 2'b10, 8'h00, 1'b0);
        step(2'b01, 2'b00, 2'b00, 8'h40, 8'h40, 8'h00, 8'h00, 2'b01, 2'b00, 8'h77, 1'b1);
        idle();

        // Back-to-back reads
        for (int k = 0; k < 4; k++)
            step(2'b01, 2'b00, 2'b00, 8'(k), 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, b2b_data[k], 1'b1);
        idle();

        // Locked read, then reset while its response is due
        step(2'b01, 2'b00, 2'b01, 8'h03, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 8'h44, 1'b0);
        @(posedge clk);
        #1 req_valid = 2'b11;
        #2 async_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk);
        #2 async_rst_n = 1'b1;

        // Port 1 must win immediately: lock was cleared by reset
        step(2'b10, 2'b00, 2'b00, 8'h00, 8'h11, 8'h00, 8'h00, 2'b10, 2'b00, 8'hB6, 1'b1);
        idle();
        idle();
        @(negedge clk);
        #1;
        chk("rsp_queue_drained", 32'(q_rsp.size()), 0);
        chk("ctl_queue_drained", 32'(q_ctl.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
